// File: rtl/final_schematic_pkg.sv
// Shared types and helpers for the parking-ticket barcode generator.
// Covers the 2-of-5 digit table, 2-digit BCD split and barcode framing.
package final_schematic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StTicketA,
        StTicketB
    } state_e;

    localparam logic [2:0] BarStart = 3'b101;
    localparam logic       BarStop  = 1'b1;

    function automatic logic [4:0] enc_digit(input logic [3:0] d);
        logic [4:0] code;
        case (d)
            4'd0:    code = 5'b00110;
            4'd1:    code = 5'b10001;
            4'd2:    code = 5'b01001;
            4'd3:    code = 5'b11000;
            4'd4:    code = 5'b00101;
            4'd5:    code = 5'b10100;
            4'd6:    code = 5'b01100;
            4'd7:    code = 5'b00011;
            4'd8:    code = 5'b10010;
            4'd9:    code = 5'b01010;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    // Returns {tens, ones}.
    function automatic logic [7:0] bin2bcd2(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = v / 6'd10;
        ones = v % 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/two_of_five_enc.sv
// Binary to N_DIGITS-digit 2-of-5 code; the most significant digit sits in the MSBs.
module two_of_five_enc
    import final_schematic_pkg::*;
#(
    parameter int unsigned N_DIGITS = 2,
    parameter int unsigned BinW     = 6
) (
    input  logic [BinW-1:0]       bin_i,
    output logic [N_DIGITS*5-1:0] code_o
);

    if (N_DIGITS == 2) begin : g_two
        logic [7:0] bcd;
        always_comb begin
            bcd    = bin2bcd2(6'(bin_i));
            code_o = {enc_digit(bcd[7:4]), enc_digit(bcd[3:0])};
        end
    end else begin : g_many
        logic [BinW-1:0] val;
        logic [3:0]      digit;
        always_comb begin
            val    = bin_i;
            digit  = '0;
            code_o = '0;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                digit              = 4'(val % BinW'(10));
                code_o[i*5 +: 5]   = enc_digit(digit);
                val                = val / BinW'(10);
            end
        end
    end

endmodule

// File: rtl/final_schematic.sv
// Parking-ticket generator: opens tickets per client, accumulates 30-minute units,
// prices them and emits the client and ticket barcodes.
module final_schematic
    import final_schematic_pkg::*;
#(
    parameter int unsigned STUDENT_A = 12345,
    parameter int unsigned STUDENT_B = 67890,
    parameter int unsigned RATE_A    = 5,
    parameter int unsigned RATE_B    = 4,
    parameter int unsigned MAX_UNITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ClientA,
    input  logic        ClientB,
    input  logic        Button30Min,
    input  logic        Button1Hour,
    input  logic        Button2Hours,
    output logic [5:0]  ValueToPay,
    output logic [24:0] StudentNumberA1,
    output logic [24:0] XLXN_30,
    output logic [48:0] XLXN_32
);

    localparam logic [5:0] RateA = 6'(RATE_A);
    localparam logic [5:0] RateB = 6'(RATE_B);
    localparam logic [6:0] MaxU  = 7'(MAX_UNITS);

    state_e     state_q, state_d;
    logic [5:0] units_q, units_d;
    logic [4:0] prev_q;
    logic [4:0] in_vec;
    logic [4:0] edge_vec;
    logic [6:0] sum;
    logic [5:0] rate;
    logic [9:0] units_code;
    logic [9:0] value_code;

    assign in_vec   = {ClientA, ClientB, Button30Min, Button1Hour, Button2Hours};
    assign edge_vec = in_vec & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            units_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            units_q <= units_d;
            prev_q  <= in_vec;
        end
    end

    always_comb begin
        state_d = state_q;
        units_d = units_q;
        sum     = {1'b0, units_q} + {6'b0, edge_vec[2]} + {5'b0, edge_vec[1], 1'b0}
                + {4'b0, edge_vec[0], 2'b0};
        // Client edges take priority over buttons; A wins over B.
        if (edge_vec[4]) begin
            state_d = StTicketA;
            units_d = '0;
        end else if (edge_vec[3]) begin
            state_d = StTicketB;
            units_d = '0;
        end else if (state_q != StIdle) begin
            units_d = (sum > MaxU) ? MaxU[5:0] : sum[5:0];
        end
    end

    always_comb begin
        case (state_q)
            StTicketA: rate = RateA;
            StTicketB: rate = RateB;
            default:   rate = '0;
        endcase
    end

    assign ValueToPay = units_q * rate;

    two_of_five_enc #(.N_DIGITS(5), .BinW(17)) u_enc_id_a (
        .bin_i  (17'(STUDENT_A)),
        .code_o (StudentNumberA1)
    );

    two_of_five_enc #(.N_DIGITS(5), .BinW(17)) u_enc_id_b (
        .bin_i  (17'(STUDENT_B)),
        .code_o (XLXN_30)
    );

    two_of_five_enc #(.N_DIGITS(2), .BinW(6)) u_enc_units (
        .bin_i  (units_q),
        .code_o (units_code)
    );

    two_of_five_enc #(.N_DIGITS(2), .BinW(6)) u_enc_value (
        .bin_i  (ValueToPay),
        .code_o (value_code)
    );

    always_comb begin
        case (state_q)
            StTicketA: XLXN_32 = {BarStart, StudentNumberA1, units_code, value_code, BarStop};
            StTicketB: XLXN_32 = {BarStart, XLXN_30, units_code, value_code, BarStop};
            default:   XLXN_32 = '0;
        endcase
    end

endmodule

// File: tb/tb_final_schematic.sv
// Directed bench for final_schematic with hand-computed barcodes and prices.
module tb_final_schematic;

    logic        clk;
    logic        rst_n;
    logic        ClientA, ClientB, Button30Min, Button1Hour, Button2Hours;
    logic [5:0]  ValueToPay;
    logic [24:0] StudentNumberA1;
    logic [24:0] XLXN_30;
    logic [48:0] XLXN_32;

    int total = 0;
    int bad   = 0;

    localparam logic [24:0] CodeA = 25'b10001_01001_11000_00101_10100;
    localparam logic [24:0] CodeB = 25'b01100_00011_10010_01010_00110;
    localparam logic [9:0]  D00   = 10'b00110_00110;

    final_schematic dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ClientA         (ClientA),
        .ClientB         (ClientB),
        .Button30Min     (Button30Min),
        .Button1Hour     (Button1Hour),
        .Button2Hours    (Button2Hours),
        .ValueToPay      (ValueToPay),
        .StudentNumberA1 (StudentNumberA1),
        .XLXN_30         (XLXN_30),
        .XLXN_32         (XLXN_32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [48:0] got, input logic [48:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive {ClientA, ClientB, 30Min, 1Hour, 2Hours} for one clock; sample after the edge.
    task automatic apply(input logic [4:0] v);
        @(negedge clk);
        {ClientA, ClientB, Button30Min, Button1Hour, Button2Hours} = v;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] v);
        apply(v);
        apply(5'b00000);
    endtask

    initial begin
        rst_n = 1'b0;
        {ClientA, ClientB, Button30Min, Button1Hour, Button2Hours} = '0;
        #12;
        check("rst_vtp", 49'(ValueToPay), 49'd0);
        check("rst_x32", XLXN_32, 49'd0);
        check("id_a", 49'(StudentNumberA1), 49'(CodeA));
        check("id_b", 49'(XLXN_30), 49'(CodeB));
        @(negedge clk);
        rst_n = 1'b1;

        pulse(5'b10000);
        check("open_a_vtp", 49'(ValueToPay), 49'd0);
        check("open_a_x32", XLXN_32, {3'b101, CodeA, D00, D00, 1'b1});
        pulse(5'b00010);
        check("a_1h_vtp", 49'(ValueToPay), 49'd10);
        check("a_1h_x32", XLXN_32, {3'b101, CodeA, 10'b00110_01001, 10'b10001_00110, 1'b1});
        pulse(5'b00001);
        check("a_2h_vtp", 49'(ValueToPay), 49'd30);
        check("a_2h_x32", XLXN_32, {3'b101, CodeA, 10'b00110_01100, 10'b11000_00110, 1'b1});

        pulse(5'b01000);
        check("open_b_vtp", 49'(ValueToPay), 49'd0);
        pulse(5'b00100);
        check("b_30_vtp", 49'(ValueToPay), 49'd4);
        check("b_30_x32", XLXN_32, {3'b101, CodeB, 10'b00110_10001, 10'b00110_00101, 1'b1});
        pulse(5'b10000);
        check("b_to_a_vtp", 49'(ValueToPay), 49'd0);
        check("b_to_a_x32", XLXN_32, {3'b101, CodeA, D00, D00, 1'b1});

        for (int i = 0; i < 3; i++) pulse(5'b00001);
        check("sat3_vtp", 49'(ValueToPay), 49'd60);
        pulse(5'b00001);
        check("sat4_vtp", 49'(ValueToPay), 49'd60);
        check("sat_x32", XLXN_32, {3'b101, CodeA, 10'b10001_01001, 10'b01100_00110, 1'b1});

        pulse(5'b10000);
        for (int i = 0; i < 10; i++) apply(5'b00010);
        apply(5'b00000);
        check("hold_vtp", 49'(ValueToPay), 49'd10);

        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        pulse(5'b00010);
        check("idle_btn_vtp", 49'(ValueToPay), 49'd0);
        check("idle_btn_x32", XLXN_32, 49'd0);

        pulse(5'b11000);
        check("ab_vtp", 49'(ValueToPay), 49'd0);
        check("ab_x32", XLXN_32, {3'b101, CodeA, D00, D00, 1'b1});
        pulse(5'b00110);
        check("combo_vtp", 49'(ValueToPay), 49'd15);
        check("combo_x32", XLXN_32, {3'b101, CodeA, 10'b00110_11000, 10'b10001_10100, 1'b1});

        // Client edge together with a button: the button is ignored.
        pulse(5'b10100);
        check("open_btn_vtp", 49'(ValueToPay), 49'd0);
        pulse(5'b00100);
        check("after_open_vtp", 49'(ValueToPay), 49'd5);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_vtp", 49'(ValueToPay), 49'd0);
        check("async_x32", XLXN_32, 49'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(5'b10000);
        check("restart_vtp", 49'(ValueToPay), 49'd0);
        pulse(5'b00100);
        check("restart_30_vtp", 49'(ValueToPay), 49'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/final_schematic.md
Name: final_schematic

Overview:
- Parking-ticket barcode generator for two fixed clients, A and B.
- A client pulse opens a ticket. Duration buttons add parking time. The block computes the amount to pay.
- Emits a fixed 25-bit barcode per client and a 49-bit ticket barcode for the open ticket.
- Barcodes use 2-of-5 digit encoding. Top level of the barcode subsystem.

Parameters:
- STUDENT_A, 12345: client A 5-digit decimal ID (0..99999).
- STUDENT_B, 67890: client B 5-digit decimal ID.
- RATE_A, 5: price per 30-min unit for client A.
- RATE_B, 4: price per 30-min unit for client B.
- MAX_UNITS, 12: duration saturation, in 30-min units. MAX_UNITS*max(RATE) must be ≤63.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ClientA  in  1  open ticket for client A (level, edge-detected)
- ClientB  in  1  open ticket for client B (level, edge-detected)
- Button30Min  in  1  add 1 unit (edge-detected)
- Button1Hour  in  1  add 2 units (edge-detected)
- Button2Hours  in  1  add 4 units (edge-detected)
- ValueToPay  out  6  units*rate of the open ticket, binary
- StudentNumberA1  out  25  2-of-5 barcode of STUDENT_A
- XLXN_30  out  25  2-of-5 barcode of STUDENT_B
- XLXN_32  out  49  ticket barcode

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); clk rising edge. All inputs are synchronous to clk.
- Edge detection: each input has a prev register. An edge occurs at clock k if the input is 1 at k and prev is 0. All prev registers reset to 0.
- States: IDLE, TICKET_A, TICKET_B. Reset → IDLE, units=0.
- Client edge, in any state → TICKET_A/TICKET_B, units cleared to 0.
  - Simultaneous A and B edges: A wins.
  - A client edge in the same cycle as button edges: buttons ignored that cycle.
- In TICKET_x, button edges add units = units + 1·e30 + 2·e1h + 4·e2h. Simultaneous edges sum. Result saturates at MAX_UNITS.
- In IDLE, button edges are ignored.
- Holding an input high adds or opens only once.
- ValueToPay:
  - Combinational from state and units.
  - IDLE → 0; TICKET_A → units*RATE_A; TICKET_B → units*RATE_B.
  - Reflects an edge at clock k immediately after edge k.
- 2-of-5 digit code, digit 0..9: 00110, 10001, 01001, 11000, 00101, 10100, 01100, 00011, 10010, 01010.
- Multi-digit code: the most significant digit occupies the MSBs.
- StudentNumberA1 and XLXN_30 are constant 5-digit encodings of their parameters, independent of reset and state.
- XLXN_32:
  - IDLE → all zeros.
  - TICKET_x → {3'b101 start, 25-bit barcode of client x, 2-digit code of units (00..12), 2-digit code of ValueToPay (00..63), 1'b1 stop}. Fields are listed MSB→LSB.
- Reset mid-ticket: immediate return to IDLE. ValueToPay=0 and XLXN_32=0 asynchronously.

Decomposition:
- Package final_schematic_pkg:
  - state enum.
  - 2-of-5 table function enc_digit (4-bit → 5-bit).
  - function bin2bcd2 (6-bit → two BCD digits).
  - start/stop pattern constants.
- One sub-module: two_of_five_enc, parameter N_DIGITS. Converts binary to BCD and encodes to N_DIGITS*5 bits. Instantiated for IDs (5 digits), units (2 digits) and value (2 digits).

Test Plan:
- Reset, then idle → ValueToPay=0, XLXN_32=0, StudentNumberA1=25'b10001_01001_11000_00101_10100, XLXN_30=25'b01100_00011_10010_01010_00110.
- ClientA pulse, then Button1Hour pulse → units 2, ValueToPay=10. Then Button2Hours → ValueToPay=30. XLXN_32 units field=digits 0,6 (00110_01100); value field=digits 3,0.
- ClientB pulse, then Button30Min → ValueToPay=4. Then ClientA pulse → ValueToPay=0 with state TICKET_A.
- ClientA, then four Button2Hours pulses → saturates at 12 units, ValueToPay=60. Holding Button1Hour high for 10 cycles adds only once.
- Button1Hour pulse in IDLE → no change (ValueToPay=0). ClientA and ClientB asserted together → TICKET_A. Buttons pressed together (30Min+1Hour) → +3 units, ValueToPay=15.
- Assert rst_n=0 mid-ticket between clock edges → outputs clear immediately. After release, the next ticket starts at 0.
